reversible_16bit_divider: RTL and testbench

Sequential unsigned integer divider, the inverse of the adder/MAC datapath. It accepts a 16-bit dividend and a 16-bit divisor on a start pulse and produces one quotient bit per clock by restoring division. Each trial subtraction is an add of the inverted divisor with carry-in 1, the same adder style as the MAC8 accumulate path. It sits beside the MAC8 core and gives the chip divide/normalise capability with a simple start/busy/done handshake.

---
 rtl/reversible_16bit_divider_if.sv | 23 ++
 rtl/reversible_16bit_divider.sv | 104 ++++++++++
 tb/tb_reversible_16bit_divider.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reversible_16bit_divider_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface reversible_16bit_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, div_by_zero
    );
endinterface

// File: rtl/reversible_16bit_divider.sv
// Restoring unsigned divider: one quotient bit per clock, trial subtract done as
// an add of the inverted divisor with carry-in 1.
module reversible_16bit_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    reversible_16bit_divider_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial;
    logic             qbit;

    // The dividend register doubles as the quotient register: each shift pushes
    // a dividend bit out of the top and the new quotient bit in at the bottom.
    // P stays below the divisor, so its top bit is always 0 and is not stored.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        p_shift = {1'b0, p_q[WIDTH-1:0]} << 1 | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        trial   = p_shift + ~{1'b0, dvs_q} + {{WIDTH{1'b0}}, 1'b1};
        qbit    = ~trial[WIDTH];

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = bus.A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                        dvd_d   = bus.A;
                        dvs_d   = bus.B;
                        p_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end
            StRun: begin
                dvd_d = {dvd_q[WIDTH-2:0], qbit};
                p_d   = qbit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    q_d     = dvd_d;
                    r_d     = p_d;
                    dbz_d   = 1'b0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_reversible_16bit_divider.sv
// Scoreboard bench for the sequential divider: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_reversible_16bit_divider;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reversible_16bit_divider_if #(.WIDTH(16)) bus ();

    reversible_16bit_divider #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   edge_cnt = 0;
    int   busy_cycles = 0;
    int   last_done = -1;
    bit   spacing_on = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.acc = acc;
        if (b == 16'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: cycle index of done counts from the accepting edge (cycle 1 follows it).
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cycles = 0;
        end else begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
                chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("quotient", {16'd0, bus.Q}, {16'd0, e.q});
                    chk("remainder", {16'd0, bus.R}, {16'd0, e.r});
                    chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                    chk("done_cycle", edge_cnt - e.acc + 1, e.dbz ? 32'd1 : 32'd17);
                    chk("busy_cycles", busy_cycles, e.dbz ? 32'd0 : 32'd16);
                    if (!e.dbz) begin
                        chk("invariant_a_eq_qb_r",
                            {16'd0, bus.Q} * {16'd0, e.b} + {16'd0, bus.R}, {16'd0, e.a});
                        chk("invariant_r_lt_b", {31'd0, bus.R < e.b}, 32'd1);
                    end
                end
                if (spacing_on && last_done >= 0) chk("done_spacing", edge_cnt - last_done, 32'd18);
                last_done   = edge_cnt;
                busy_cycles = 0;
            end
        end
    end

    // Inputs are driven 1 time unit after a rising edge; the next rising edge samples them.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        sb.push_back(model(a, b, edge_cnt));
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic div_one(input logic [15:0] a, input logic [15:0] b);
        start_op(a, b);
        wait_done();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] na, nb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'd0;
        bus.B     = 16'd0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_q", {16'd0, bus.Q}, 32'd0);
        chk("reset_r", {16'd0, bus.R}, 32'd0);
        chk("reset_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        step();

        div_one(16'h03E8, 16'h0007);
        chk("directed_q_1000_div_7", {16'd0, bus.Q}, 32'h008E);
        chk("directed_r_1000_div_7", {16'd0, bus.R}, 32'h0006);
        div_one(16'hFFFF, 16'h0001);
        div_one(16'h0005, 16'h0009);
        div_one(16'h8000, 16'hFFFF);
        div_one(16'h1234, 16'h0000);
        div_one(16'd50, 16'd7);

        // A second start mid-run must be ignored.
        start_op(16'd100, 16'd10);
        repeat (4) step();
        bus.start = 1'b1;
        bus.A     = 16'd7;
        bus.B     = 16'd7;
        step();
        bus.start = 1'b0;
        wait_done();
        repeat (25) step();
        chk("ignored_start_q", {16'd0, bus.Q}, 32'h000A);
        chk("ignored_start_r", {16'd0, bus.R}, 32'h0000);

        // Reset in cycle 8 aborts the division.
        start_op(16'h1234, 16'h0056);
        repeat (7) step();
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_q", {16'd0, bus.Q}, 32'd0);
        chk("abort_r", {16'd0, bus.R}, 32'd0);
        chk("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        step();
        div_one(16'h00FF, 16'h0010);

        // Single random operations, occasionally dividing by zero.
        for (int i = 0; i < 10; i++) begin
            na = 16'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            div_one(na, nb);
        end

        // Back-to-back operations with start held high.
        last_done  = -1;
        spacing_on = 1'b1;
        na = 16'($urandom);
        nb = 16'($urandom_range(1, 65535));
        start_op(na, nb);
        bus.start = 1'b1;
        for (int i = 1; i < 20; i++) begin
            na = 16'($urandom);
            nb = (i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            bus.A = na;
            bus.B = nb;
            wait_done();
            @(posedge clk);
            @(posedge clk);
            #1;
            sb.push_back(model(na, nb, edge_cnt));
        end
        bus.start = 1'b0;
        wait_done();
        step();
        spacing_on = 1'b0;
        repeat (25) step();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
